// File: rtl/hermes_switch_control.sv
// Hermes router control: round-robin arbitration over header requests, XY routing,
// and allocation/release of crossbar output ports. One connection is set up per round.
module hermes_switch_control #(
    parameter int          FLIT_SIZE = 32,
    parameter logic [15:0] ADDRESS   = 16'h0000
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [4:0]                     req_i,
    input  logic [4:0][FLIT_SIZE-1:0]      header_i,
    input  logic [4:0]                     sending_i,
    output logic [4:0]                     ack_h_o,
    output logic [4:0]                     free_o,
    output logic [4:0][2:0]                inport_o,
    output logic [4:0][2:0]                outport_o
);

    localparam int NPORT = 5;

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_ROUTE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [2:0]            sel_q, sel_d;
    logic [2:0]            last_q, last_d;
    logic [NPORT-1:0]      sending_q;
    logic [NPORT-1:0]      ack_q, ack_d;
    logic [NPORT-1:0]      free_q, free_d;
    logic [NPORT-1:0][2:0] inport_q, inport_d;
    logic [NPORT-1:0][2:0] outport_q, outport_d;

    logic [2:0] winner;
    logic       found;
    logic [2:0] route_dir;
    logic       unused_header_bits;

    assign unused_header_bits = ^header_i;

    function automatic logic [2:0] xy_route(input logic [15:0] target);
        logic [7:0] tx, ty;
        tx = target[15:8];
        ty = target[7:0];
        if (tx > ADDRESS[15:8])      return EAST;
        else if (tx < ADDRESS[15:8]) return WEST;
        else if (ty > ADDRESS[7:0])  return NORTH;
        else if (ty < ADDRESS[7:0])  return SOUTH;
        else                         return LOCAL;
    endfunction

    // Search starts one past the last served input, wrapping LOCAL -> EAST.
    always_comb begin
        logic [2:0] cand;
        cand   = last_q;
        winner = sel_q;
        found  = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            cand = (cand == LOCAL) ? EAST : cand + 3'd1;
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign route_dir = xy_route(header_i[sel_q][15:0]);

    always_comb begin
        // NOTE: every _d gets a default before any branch so no latch is inferred.
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        ack_d     = '0;
        free_d    = free_q;
        inport_d  = inport_q;
        outport_d = outport_q;

        // Falling edge of sending frees that input's output; several may fall at once.
        for (int i = 0; i < NPORT; i++) begin
            if (sending_q[i] && !sending_i[i]) free_d[outport_q[i]] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (|req_i) state_d = S_ARB;
            end
            S_ARB: begin
                if (found) begin
                    sel_d   = winner;
                    state_d = S_ROUTE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUTE: begin
                last_d  = sel_q;
                state_d = S_IDLE;
                // Grant only on the registered free flag: a same-cycle release is not bypassed.
                if (free_q[route_dir]) begin
                    free_d[route_dir]  = 1'b0;
                    inport_d[route_dir] = sel_q;
                    outport_d[sel_q]   = route_dir;
                    ack_d[sel_q]       = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            sel_q     <= EAST;
            last_q    <= LOCAL;
            sending_q <= '0;
            ack_q     <= '0;
            free_q    <= '1;
            inport_q  <= '0;
            outport_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            sending_q <= sending_i;
            ack_q     <= ack_d;
            free_q    <= free_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
        end
    end

    assign ack_h_o   = ack_q;
    assign free_o    = free_q;
    assign inport_o  = inport_q;
    assign outport_o = outport_q;

endmodule
